digit_font_scheduler: RTL

Time-multiplexes the single shared BCD decoder and font ROM across all 18 on-screen digit slots of the RTC display: date, time and chronometer rows, six digits each. Once per frame it snapshots the digit values from the RTC register side through a request/acknowledge handshake. Every pixel clock it decides which slot owns the current pixel and issues the ROM lookup. It then realigns the returned font byte with the pixel pipeline and drives the text RGB toward the VGA mixer.

---
 rtl/rtc_disp_pkg.sv | 81 ++++++++
 rtl/slot_locator.sv | 47 ++++
 rtl/digit_font_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rtc_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_disp_pkg
// Description : Shared constants and types for the RTC digit display: band
//               and column geometry, snapshot FSM states, blank BCD code.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_disp_pkg;

    // Slot geometry in pixels
    localparam logic [9:0] SLOT_W    = 10'd32;
    localparam logic [9:0] SLOT_H    = 10'd64;
    localparam int         NUM_BANDS = 3;
    localparam int         NUM_COLS  = 6;

    // Band vertical bounds (inclusive)
    localparam logic [9:0] HORA_Y0   = 10'd64;
    localparam logic [9:0] HORA_Y1   = 10'd127;
    localparam logic [9:0] FECHA_Y0  = 10'd192;
    localparam logic [9:0] FECHA_Y1  = 10'd255;
    localparam logic [9:0] CRONO_Y0  = 10'd320;
    localparam logic [9:0] CRONO_Y1  = 10'd383;

    // Band codes as reported by the slot locator
    localparam logic [1:0] BAND_HORA  = 2'd0;
    localparam logic [1:0] BAND_FECHA = 2'd1;
    localparam logic [1:0] BAND_CRONO = 2'd2;

    // Column x starts
    localparam logic [9:0] COL_X0 = 10'd160;
    localparam logic [9:0] COL_X1 = 10'd192;
    localparam logic [9:0] COL_X2 = 10'd320;
    localparam logic [9:0] COL_X3 = 10'd352;
    localparam logic [9:0] COL_X4 = 10'd480;
    localparam logic [9:0] COL_X5 = 10'd512;

    // Code stored in the shadow bank for an empty/blank digit
    localparam logic [3:0] BLANK_BCD = 4'hF;

    // Snapshot handshake states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } snap_state_t;

    function automatic logic [9:0] band_y0(input int b);
        case (b)
            0:       band_y0 = HORA_Y0;
            1:       band_y0 = FECHA_Y0;
            default: band_y0 = CRONO_Y0;
        endcase
    endfunction

    function automatic logic [9:0] band_y1(input int b);
        case (b)
            0:       band_y1 = HORA_Y1;
            1:       band_y1 = FECHA_Y1;
            default: band_y1 = CRONO_Y1;
        endcase
    endfunction

    function automatic logic [9:0] col_x0(input int k);
        case (k)
            0:       col_x0 = COL_X0;
            1:       col_x0 = COL_X1;
            2:       col_x0 = COL_X2;
            3:       col_x0 = COL_X3;
            4:       col_x0 = COL_X4;
            default: col_x0 = COL_X5;
        endcase
    endfunction

    // Swap nibbles so the upper (first-displayed) digit lands in the lower
    // nibble position of the flattened shadow bank.
    function automatic logic [7:0] nib_swap(input logic [7:0] b);
        nib_swap = {b[3:0], b[7:4]};
    endfunction

endpackage : rtc_disp_pkg
`default_nettype wire

// File: rtl/slot_locator.sv
`default_nettype none
// ============================================================================
// Module      : slot_locator
// Description : Combinational map from pixel coordinates to the digit slot
//               that owns the pixel: {hit, band, slot}.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_locator
    import rtc_disp_pkg::*;
(
    input  logic [9:0] i_pix_x,
    input  logic [9:0] i_pix_y,
    output logic       o_hit,
    output logic [1:0] o_band,
    output logic [2:0] o_slot
);

    logic       w_band_hit;
    logic       w_col_hit;
    logic [1:0] w_band;
    logic [2:0] w_slot;

    // Range-compare the pixel against every band and column window
    always_comb begin
        w_band_hit = 1'b0;
        w_band     = 2'd0;
        w_col_hit  = 1'b0;
        w_slot     = 3'd0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            if (i_pix_y >= band_y0(b) && i_pix_y <= band_y1(b)) begin
                w_band_hit = 1'b1;
                w_band     = 2'(b);
            end
        end
        for (int k = 0; k < NUM_COLS; k++) begin
            if (i_pix_x >= col_x0(k) && i_pix_x <= col_x0(k) + SLOT_W - 10'd1) begin
                w_col_hit = 1'b1;
                w_slot    = 3'(k);
            end
        end
        o_hit  = w_band_hit & w_col_hit;
        o_band = o_hit ? w_band : 2'd0;
        o_slot = o_hit ? w_slot : 3'd0;
    end

endmodule : slot_locator
`default_nettype wire

// File: rtl/digit_font_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : digit_font_scheduler
// Description : Shares one BCD decoder / font ROM across the 18 display
//               digit slots. Snapshots RTC digits once per frame via a
//               req/ack handshake, issues per-pixel ROM lookups and aligns
//               the returned font byte with the pixel pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_font_scheduler
    import rtc_disp_pkg::*;
#(
    parameter int          ROW_SHIFT = 2,
    parameter logic [11:0] TXT_COLOR = 12'hFFF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        video_on,
    input  logic [7:0]  fecha_in1,
    input  logic [7:0]  fecha_in2,
    input  logic [7:0]  fecha_in3,
    input  logic [7:0]  hora_in1,
    input  logic [7:0]  hora_in2,
    input  logic [7:0]  hora_in3,
    input  logic [7:0]  crono_in1,
    input  logic [7:0]  crono_in2,
    input  logic [7:0]  crono_in3,
    input  logic        upd_ack,
    output logic        upd_req,
    output logic        stale,
    output logic [3:0]  rom_digit,
    output logic [3:0]  rom_row,
    input  logic [7:0]  rom_data,
    output logic [11:0] rgbtext
);

    // Snapshot FSM and shadow bank (18 nibbles, index = band*6 + slot)
    snap_state_t r_state;
    logic        r_upd_req;
    logic        r_stale;
    logic [71:0] r_shadow;

    // Lookup pipeline
    logic [3:0]  r_rom_digit;
    logic [3:0]  r_rom_row;
    logic [2:0]  r_col1;
    logic        r_hit1;
    logic        r_vid1;
    logic [2:0]  r_col2;
    logic        r_hit2;
    logic        r_vid2;

    logic        w_loc_hit;
    logic [1:0]  w_loc_band;
    logic [2:0]  w_loc_slot;
    logic [4:0]  w_idx;
    logic [3:0]  w_nib;
    logic        w_digit_ok;
    logic [3:0]  w_glyph_row;

    slot_locator u_slot_locator (
        .i_pix_x (pix_x),
        .i_pix_y (pix_y),
        .o_hit   (w_loc_hit),
        .o_band  (w_loc_band),
        .o_slot  (w_loc_slot)
    );

    // Fetch the shadowed digit for the owning slot; codes above 9 render blank
    always_comb begin
        w_idx       = 5'(w_loc_band) * 5'd6 + 5'(w_loc_slot);
        w_nib       = r_shadow[{w_idx, 2'b00} +: 4];
        w_digit_ok  = w_loc_hit && (w_nib <= 4'd9);
        w_glyph_row = pix_y[ROW_SHIFT+3:ROW_SHIFT];
    end

    // Per-frame snapshot handshake; ack wins over the y==0 timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_upd_req <= 1'b0;
            r_stale   <= 1'b0;
            r_shadow  <= {18{BLANK_BCD}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pix_y == 10'd480 && pix_x == 10'd0) begin
                        r_state   <= ST_REQ;
                        r_upd_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (upd_ack) begin
                        r_shadow  <= {nib_swap(crono_in3), nib_swap(crono_in2), nib_swap(crono_in1),
                                      nib_swap(fecha_in3), nib_swap(fecha_in2), nib_swap(fecha_in1),
                                      nib_swap(hora_in3),  nib_swap(hora_in2),  nib_swap(hora_in1)};
                        r_stale   <= 1'b0;
                        r_upd_req <= 1'b0;
                        r_state   <= ST_HOLD;
                    end else if (pix_y == 10'd0) begin
                        r_stale   <= 1'b1;
                        r_upd_req <= 1'b0;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (pix_y == 10'd1) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_upd_req <= 1'b0;
                end
            endcase
        end
    end

    // S1 issues the ROM address; S2 carries column/hit/vid to meet rom_data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rom_digit <= 4'd0;
            r_rom_row   <= 4'd0;
            r_col1      <= 3'd0;
            r_hit1      <= 1'b0;
            r_vid1      <= 1'b0;
            r_col2      <= 3'd0;
            r_hit2      <= 1'b0;
            r_vid2      <= 1'b0;
        end else begin
            r_rom_digit <= w_digit_ok ? w_nib : 4'd0;
            r_rom_row   <= w_digit_ok ? w_glyph_row : 4'd0;
            r_col1      <= pix_x[4:2];
            r_hit1      <= w_digit_ok;
            r_vid1      <= video_on;
            r_col2      <= r_col1;
            r_hit2      <= r_hit1;
            r_vid2      <= r_vid1;
        end
    end

    // rom_data comes straight off the font ROM's output register, so the
    // final bit pick stays a short mux gated by pipeline registers.
    assign rgbtext   = (r_vid2 && r_hit2 && rom_data[3'd7 - r_col2]) ? TXT_COLOR : 12'h000;
    assign upd_req   = r_upd_req;
    assign stale     = r_stale;
    assign rom_digit = r_rom_digit;
    assign rom_row   = r_rom_row;

endmodule : digit_font_scheduler
`default_nettype wire
